// File: rtl/regfile_port_seq.sv
// ---------------------------------------------------------------------------
// regfile_port_seq
// Shares one single-ported register-file array between the decode stage
// (two operand reads srcA/srcB) and the write-back stage (two result writes
// dstE/dstM). Requests arrive over valid/ready handshakes, are serialized
// onto the array port by a small FSM and complete with one-cycle done pulses.
// Register ID RNONE means "no register": it is skipped and costs no port cycle.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   rd_valid_i/rd_ready_o     read request handshake (srcA_i, srcB_i)
//   rd_done_o, valA_o, valB_o read completion pulse and operand values
//   wr_valid_i/wr_ready_o     write request handshake (dstE_i/valE_i, dstM_i/valM_i)
//   wr_done_o                 write completion pulse
//   busy_o                    FSM not idle
//   rf_addr_o, rf_we_o, rf_wdata_o, rf_rdata_i   array port
// ---------------------------------------------------------------------------
module regfile_port_seq #(
    parameter int          DATA_W = 64,
    parameter logic [3:0]  RNONE  = 4'hF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_valid_i,
    output logic              rd_ready_o,
    input  logic [3:0]        srcA_i,
    input  logic [3:0]        srcB_i,
    output logic              rd_done_o,
    output logic [DATA_W-1:0] valA_o,
    output logic [DATA_W-1:0] valB_o,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [3:0]        dstE_i,
    input  logic [3:0]        dstM_i,
    input  logic [DATA_W-1:0] valE_i,
    input  logic [DATA_W-1:0] valM_i,
    output logic              wr_done_o,
    output logic              busy_o,
    output logic [3:0]        rf_addr_o,
    output logic              rf_we_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    input  logic [DATA_W-1:0] rf_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR_E = 3'd1,
        S_WR_M = 3'd2,
        S_RD_A = 3'd3,
        S_RD_B = 3'd4,
        S_RD_W = 3'd5
    } state_t;

    localparam logic [DATA_W-1:0] ZERO_W = {DATA_W{1'b0}};

    state_t            state_q, state_d;
    logic [3:0]        src_a_q, src_a_d, src_b_q, src_b_d;
    logic [3:0]        dst_e_q, dst_e_d, dst_m_q, dst_m_d;
    logic [DATA_W-1:0] val_e_q, val_e_d, val_m_q, val_m_d;
    logic [DATA_W-1:0] stage_a_q, stage_a_d;
    logic [DATA_W-1:0] val_a_q, val_a_d, val_b_q, val_b_d;
    logic              rd_done_q, rd_done_d, wr_done_q, wr_done_d;
    logic              busy_q;
    logic [3:0]        rf_addr_q, rf_addr_d;
    logic              rf_we_q, rf_we_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              idle_s, wr_acc_s, rd_acc_s;

    // Writes win arbitration so write-back commits before the younger decode reads.
    assign idle_s     = (state_q == S_IDLE);
    assign wr_ready_o = !rst_i && idle_s;
    assign rd_ready_o = !rst_i && idle_s && !wr_valid_i;
    assign wr_acc_s   = idle_s && wr_valid_i;
    assign rd_acc_s   = idle_s && rd_valid_i && !wr_valid_i;

    // State register and all registered datapath/outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            src_a_q    <= 4'h0;
            src_b_q    <= 4'h0;
            dst_e_q    <= 4'h0;
            dst_m_q    <= 4'h0;
            val_e_q    <= ZERO_W;
            val_m_q    <= ZERO_W;
            stage_a_q  <= ZERO_W;
            val_a_q    <= ZERO_W;
            val_b_q    <= ZERO_W;
            rd_done_q  <= 1'b0;
            wr_done_q  <= 1'b0;
            busy_q     <= 1'b0;
            rf_addr_q  <= 4'h0;
            rf_we_q    <= 1'b0;
            rf_wdata_q <= ZERO_W;
        end else begin
            state_q    <= state_d;
            src_a_q    <= src_a_d;
            src_b_q    <= src_b_d;
            dst_e_q    <= dst_e_d;
            dst_m_q    <= dst_m_d;
            val_e_q    <= val_e_d;
            val_m_q    <= val_m_d;
            stage_a_q  <= stage_a_d;
            val_a_q    <= val_a_d;
            val_b_q    <= val_b_d;
            rd_done_q  <= rd_done_d;
            wr_done_q  <= wr_done_d;
            busy_q     <= (state_d != S_IDLE);
            rf_addr_q  <= rf_addr_d;
            rf_we_q    <= rf_we_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Request capture at acceptance; held otherwise.
    always_comb begin
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        dst_e_d = dst_e_q;
        dst_m_d = dst_m_q;
        val_e_d = val_e_q;
        val_m_d = val_m_q;
        if (wr_acc_s) begin
            dst_e_d = dstE_i;
            dst_m_d = dstM_i;
            val_e_d = valE_i;
            val_m_d = valM_i;
        end else if (rd_acc_s) begin
            src_a_d = srcA_i;
            src_b_d = srcB_i;
        end else begin
            src_a_d = src_a_q;
        end
    end

    // Next-state logic; RNONE IDs skip their port cycle entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (wr_acc_s) begin
                    if (dstE_i != RNONE)      state_d = S_WR_E;
                    else if (dstM_i != RNONE) state_d = S_WR_M;
                    else                      state_d = S_IDLE;
                end else if (rd_acc_s) begin
                    if (srcA_i != RNONE)      state_d = S_RD_A;
                    else if (srcB_i != RNONE) state_d = S_RD_B;
                    else                      state_d = S_IDLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_E:  state_d = (dst_m_q != RNONE) ? S_WR_M : S_IDLE;
            S_WR_M:  state_d = S_IDLE;
            S_RD_A:  state_d = (src_b_q != RNONE) ? S_RD_B : S_RD_W;
            S_RD_B:  state_d = S_RD_W;
            S_RD_W:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: port drive follows the upcoming state so rf_* are registered;
    // read data arrives one cycle after its address and is staged until done.
    always_comb begin
        rf_addr_d  = 4'h0;
        rf_we_d    = 1'b0;
        rf_wdata_d = ZERO_W;
        case (state_d)
            S_WR_E: begin
                rf_addr_d  = dst_e_d;
                rf_we_d    = 1'b1;
                rf_wdata_d = val_e_d;
            end
            S_WR_M: begin
                rf_addr_d  = dst_m_d;
                rf_we_d    = 1'b1;
                rf_wdata_d = val_m_d;
            end
            S_RD_A:  rf_addr_d = src_a_d;
            S_RD_B:  rf_addr_d = src_b_d;
            default: rf_addr_d = 4'h0;
        endcase

        stage_a_d = stage_a_q;
        val_a_d   = val_a_q;
        val_b_d   = val_b_q;
        case (state_q)
            S_RD_B: stage_a_d = (src_a_q != RNONE) ? rf_rdata_i : ZERO_W;
            S_RD_W: begin
                // The last issued read is srcB if present, otherwise srcA.
                if (src_b_q != RNONE) begin
                    val_a_d = (src_a_q != RNONE) ? stage_a_q : ZERO_W;
                    val_b_d = rf_rdata_i;
                end else begin
                    val_a_d = rf_rdata_i;
                    val_b_d = ZERO_W;
                end
            end
            S_IDLE: begin
                if (rd_acc_s && (srcA_i == RNONE) && (srcB_i == RNONE)) begin
                    val_a_d = ZERO_W;
                    val_b_d = ZERO_W;
                end else begin
                    val_a_d = val_a_q;
                end
            end
            default: stage_a_d = stage_a_q;
        endcase

        rd_done_d = (state_q == S_RD_W) ||
                    (rd_acc_s && (srcA_i == RNONE) && (srcB_i == RNONE));
        wr_done_d = (((state_q == S_WR_E) || (state_q == S_WR_M)) && (state_d == S_IDLE)) ||
                    (wr_acc_s && (dstE_i == RNONE) && (dstM_i == RNONE));
    end

    assign valA_o     = val_a_q;
    assign valB_o     = val_b_q;
    assign rd_done_o  = rd_done_q;
    assign wr_done_o  = wr_done_q;
    assign busy_o     = busy_q;
    assign rf_addr_o  = rf_addr_q;
    assign rf_we_o    = rf_we_q;
    assign rf_wdata_o = rf_wdata_q;

endmodule
